// File: rtl/alarm_setting_pkg.sv
// Shared types and limits for the alarm setpoint editor.
package alarm_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned FIELD_W = 8;

  localparam logic [FIELD_W-1:0] HOUR_MAX   = 8'h23;
  localparam logic [FIELD_W-1:0] MINSEC_MAX = 8'h59;

  // Encoding doubles as the edit_field display code.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

endpackage

// File: rtl/alarm_setting_if.sv
// Key inputs and committed setpoint / edit status outputs of the alarm editor.
interface alarm_setting_if;

  logic                        key_mode_n;
  logic                        key_inc_n;
  logic                        key_dec_n;
  logic [alarm_pkg::DIGIT_W-1:0] alarm_secL;
  logic [alarm_pkg::DIGIT_W-1:0] alarm_secH;
  logic [alarm_pkg::DIGIT_W-1:0] alarm_minL;
  logic [alarm_pkg::DIGIT_W-1:0] alarm_minH;
  logic [alarm_pkg::DIGIT_W-1:0] alarm_hourL;
  logic [alarm_pkg::DIGIT_W-1:0] alarm_hourH;
  logic [1:0]                  edit_field;
  logic                        editing;

  modport master (
    output key_mode_n, key_inc_n, key_dec_n,
    input  alarm_secL, alarm_secH, alarm_minL, alarm_minH, alarm_hourL, alarm_hourH,
    input  edit_field, editing
  );

  modport slave (
    input  key_mode_n, key_inc_n, key_dec_n,
    output alarm_secL, alarm_secH, alarm_minL, alarm_minH, alarm_hourL, alarm_hourH,
    output edit_field, editing
  );

endinterface

// File: rtl/alarm_setting_bcd_field_adj.sv
// Combinational +/-1 of a two-digit BCD field, wrapping between 00 and max.
module bcd_field_adj
  import alarm_pkg::*;
(
  input  logic [FIELD_W-1:0] i_val,
  input  logic               i_inc,
  input  logic               i_dec,
  input  logic [FIELD_W-1:0] i_max,
  output logic [FIELD_W-1:0] o_val
);

  logic [DIGIT_W-1:0] w_lo;
  logic [DIGIT_W-1:0] w_hi;

  assign w_lo = i_val[DIGIT_W-1:0];
  assign w_hi = i_val[FIELD_W-1:DIGIT_W];

  always_comb begin
    o_val = i_val;
    if (i_inc && !i_dec) begin
      if (i_val == i_max)         o_val = '0;
      else if (w_lo == 4'd9)      o_val = {DIGIT_W'(w_hi + 4'd1), 4'd0};
      else                        o_val = {w_hi, DIGIT_W'(w_lo + 4'd1)};
    end else if (i_dec && !i_inc) begin
      if (i_val == '0)            o_val = i_max;
      else if (w_lo == 4'd0)      o_val = {DIGIT_W'(w_hi - 4'd1), 4'd9};
      else                        o_val = {w_hi, DIGIT_W'(w_lo - 4'd1)};
    end
  end

endmodule

// File: rtl/alarm_setting.sv
// Alarm setpoint editor: mode/inc/dec keys edit a shadow copy, committed on exit.
module alarm_setting
  import alarm_pkg::*;
#(
  parameter logic [FIELD_W-1:0] RST_HOUR = 8'h07,
  parameter logic [FIELD_W-1:0] RST_MIN  = 8'h00,
  parameter logic [FIELD_W-1:0] RST_SEC  = 8'h00
) (
  input  logic            div_clk,
  input  logic            rst_n,
  alarm_setting_if.slave  bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_mode_prev, r_inc_prev, r_dec_prev;
  logic               w_mode_p, w_inc_p, w_dec_p;
  logic               w_load, w_commit, w_adj_en;
  logic [FIELD_W-1:0] r_sh_hour, r_sh_min, r_sh_sec;
  logic [FIELD_W-1:0] r_hour, r_min, r_sec;
  logic [FIELD_W-1:0] w_sel_val, w_sel_max, w_adj_val;

  // Previous-value registers reset low so a key held through reset never fires.
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_prev <= 1'b0;
      r_inc_prev  <= 1'b0;
      r_dec_prev  <= 1'b0;
    end else begin
      r_mode_prev <= bus.key_mode_n;
      r_inc_prev  <= bus.key_inc_n;
      r_dec_prev  <= bus.key_dec_n;
    end
  end

  assign w_mode_p = r_mode_prev && !bus.key_mode_n;
  assign w_inc_p  = r_inc_prev  && !bus.key_inc_n;
  assign w_dec_p  = r_dec_prev  && !bus.key_dec_n;

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    if (w_mode_p) begin
      case (r_state)
        IDLE:     begin w_state_nxt = SET_HOUR; w_load = 1'b1; end
        SET_HOUR: w_state_nxt = SET_MIN;
        SET_MIN:  w_state_nxt = SET_SEC;
        SET_SEC:  begin w_state_nxt = IDLE; w_commit = 1'b1; end
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  // Mode wins over a coincident adjustment.
  assign w_adj_en = (w_inc_p || w_dec_p) && !w_mode_p && (r_state != IDLE);

  always_comb begin
    w_sel_val = r_sh_hour;
    w_sel_max = HOUR_MAX;
    case (r_state)
      SET_MIN: begin w_sel_val = r_sh_min; w_sel_max = MINSEC_MAX; end
      SET_SEC: begin w_sel_val = r_sh_sec; w_sel_max = MINSEC_MAX; end
      default: ;
    endcase
  end

  bcd_field_adj u_adj (
    .i_val (w_sel_val),
    .i_inc (w_inc_p),
    .i_dec (w_dec_p),
    .i_max (w_sel_max),
    .o_val (w_adj_val)
  );

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_hour <= RST_HOUR;
      r_sh_min  <= RST_MIN;
      r_sh_sec  <= RST_SEC;
    end else if (w_load) begin
      r_sh_hour <= r_hour;
      r_sh_min  <= r_min;
      r_sh_sec  <= r_sec;
    end else if (w_adj_en) begin
      case (r_state)
        SET_HOUR: r_sh_hour <= w_adj_val;
        SET_MIN:  r_sh_min  <= w_adj_val;
        SET_SEC:  r_sh_sec  <= w_adj_val;
        default:  ;
      endcase
    end
  end

  // All six digits update on one edge so the comparator never sees a mixed time.
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hour <= RST_HOUR;
      r_min  <= RST_MIN;
      r_sec  <= RST_SEC;
    end else if (w_commit) begin
      r_hour <= r_sh_hour;
      r_min  <= r_sh_min;
      r_sec  <= r_sh_sec;
    end
  end

  assign bus.alarm_hourH = r_hour[FIELD_W-1:DIGIT_W];
  assign bus.alarm_hourL = r_hour[DIGIT_W-1:0];
  assign bus.alarm_minH  = r_min[FIELD_W-1:DIGIT_W];
  assign bus.alarm_minL  = r_min[DIGIT_W-1:0];
  assign bus.alarm_secH  = r_sec[FIELD_W-1:DIGIT_W];
  assign bus.alarm_secL  = r_sec[DIGIT_W-1:0];
  assign bus.edit_field  = 2'(r_state);
  assign bus.editing     = (r_state != IDLE);

endmodule

// File: tb/tb_alarm_setting.sv
// Directed bench for alarm_setting: edit sequences, wraps, key collisions, reset.
module tb_alarm_setting;

  logic div_clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  alarm_setting_if bus ();

  alarm_setting #(
    .RST_HOUR (8'h07),
    .RST_MIN  (8'h00),
    .RST_SEC  (8'h00)
  ) dut (
    .div_clk (div_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 div_clk = ~div_clk;

  function automatic logic [23:0] hms();
    return {bus.alarm_hourH, bus.alarm_hourL, bus.alarm_minH,
            bus.alarm_minL, bus.alarm_secH, bus.alarm_secL};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic press_mode();
    bus.key_mode_n = 1'b0; tick();
    bus.key_mode_n = 1'b1; tick();
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      bus.key_inc_n = 1'b0; tick();
      bus.key_inc_n = 1'b1; tick();
    end
  endtask

  task automatic press_dec(input int n);
    for (int i = 0; i < n; i++) begin
      bus.key_dec_n = 1'b0; tick();
      bus.key_dec_n = 1'b1; tick();
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    div_clk = 1'b0;
    rst_n = 1'b0;
    bus.key_mode_n = 1'b0;
    bus.key_inc_n  = 1'b1;
    bus.key_dec_n  = 1'b1;

    // Reset with mode held low, then release: no transition.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("rst_time", 32'(hms()), 32'h070000);
    check("rst_field", 32'(bus.edit_field), 32'd0);
    check("rst_editing", 32'(bus.editing), 32'd0);
    bus.key_mode_n = 1'b1;
    repeat (2) tick();
    check("held_mode_no_fire", 32'(bus.edit_field), 32'd0);

    // Full edit: hour +3, minute -1, second +2.
    bus.key_mode_n = 1'b0; tick();
    check("enter_hour_field", 32'(bus.edit_field), 32'd1);
    check("enter_hour_editing", 32'(bus.editing), 32'd1);
    bus.key_mode_n = 1'b1; tick();
    press_inc(3);
    check("hour_edit_stable", 32'(hms()), 32'h070000);
    press_mode();
    check("min_field", 32'(bus.edit_field), 32'd2);
    press_dec(1);
    press_mode();
    check("sec_field", 32'(bus.edit_field), 32'd3);
    press_inc(2);
    check("sec_edit_stable", 32'(hms()), 32'h070000);
    press_mode();
    check("commit_time", 32'(hms()), 32'h105902);
    check("commit_field", 32'(bus.edit_field), 32'd0);
    check("commit_editing", 32'(bus.editing), 32'd0);

    // Hour up to 23 then wrap both ways.
    press_mode(); press_inc(13); press_mode(); press_mode(); press_mode();
    check("hour_23", 32'(hms()), 32'h235902);
    press_mode(); press_inc(1); press_mode(); press_mode(); press_mode();
    check("hour_wrap_inc", 32'(hms()), 32'h005902);
    press_mode(); press_dec(1); press_mode();
    press_inc(10); press_mode(); press_mode();
    check("hour_wrap_dec_min_09", 32'(hms()), 32'h230902);
    press_mode(); press_mode(); press_inc(1); press_mode(); press_mode();
    check("min_carry_10", 32'(hms()), 32'h231002);

    // Minute borrow, then inc+dec together leaves it alone.
    press_mode(); press_mode(); press_dec(1);
    bus.key_inc_n = 1'b0; bus.key_dec_n = 1'b0; tick();
    bus.key_inc_n = 1'b1; bus.key_dec_n = 1'b1; tick();
    press_mode(); press_mode();
    check("min_borrow_and_incdec", 32'(hms()), 32'h230902);

    // Mode with inc in SET_HOUR: advance, drop the increment.
    press_mode();
    bus.key_mode_n = 1'b0; bus.key_inc_n = 1'b0; tick();
    check("mode_inc_field", 32'(bus.edit_field), 32'd2);
    bus.key_mode_n = 1'b1; bus.key_inc_n = 1'b1; tick();
    press_mode(); press_mode();
    check("mode_inc_hour_kept", 32'(hms()), 32'h230902);

    // Held inc for 20 cycles in SET_SEC counts once.
    press_mode(); press_mode(); press_mode();
    bus.key_inc_n = 1'b0;
    repeat (20) tick();
    bus.key_inc_n = 1'b1; tick();
    press_mode();
    check("held_inc_once", 32'(hms()), 32'h230903);

    // inc/dec in IDLE ignored; a no-edit pass recommits the same time.
    press_inc(2); press_dec(1);
    check("idle_keys_field", 32'(bus.edit_field), 32'd0);
    press_mode(); press_mode(); press_mode(); press_mode();
    check("idle_keys_time", 32'(hms()), 32'h230903);

    // Reset mid-edit discards the shadow and reloads defaults.
    press_mode(); press_mode(); press_inc(2);
    rst_n = 1'b0; #1;
    check("midrst_time", 32'(hms()), 32'h070000);
    check("midrst_field", 32'(bus.edit_field), 32'd0);
    tick();
    rst_n = 1'b1; tick(); tick();
    check("post_rst_editing", 32'(bus.editing), 32'd0);
    press_mode(); press_mode(); press_mode(); press_inc(1); press_mode();
    check("post_rst_shadow", 32'(hms()), 32'h070001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
